// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode and FSM state types, flag bit positions and a
// flag-packing helper for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_PASS_A = 4'b0010,
        OP_PASS_B = 4'b0011,
        OP_MOD    = 4'b0100,
        OP_AND    = 4'b0101,
        OP_MUL    = 4'b0110,
        OP_SHR    = 4'b0111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

    // Assemble the 4-bit flag vector from its individual conditions
    function automatic logic [3:0] pack_flags(input logic neg, input logic zero,
                                              input logic carry, input logic ovf);
        logic [3:0] f;
        f            = '0;
        f[FLAG_NEG]   = neg;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        f[FLAG_OVF]   = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: iterative datapath shared by multiply (shift-add) and modulo
// (restoring division). One bit is processed per clock for N clocks after a
// start pulse. Only instantiated when ALU_SEQ_MULDIV_EN is defined.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  opcode_t      op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] res,
    output logic         carry,
    output logic         div0,
    output logic         last
);

    localparam int CW = $clog2(N) + 1;

    logic [CW-1:0] count_q;
    logic          is_mod_q;
    logic [N-1:0]  hi_q;
    logic [N-1:0]  lo_q;
    logic [N-1:0]  opb_q;

    logic [N:0]    mul_sum;
    logic [N:0]    rem_shift;
    logic [N:0]    rem_trial;
    logic [N-1:0]  hi_d;
    logic [N-1:0]  lo_d;

    // One iteration step: shift-add for multiply, shift-subtract-restore for modulo
    always_comb begin
        mul_sum   = '0;
        rem_shift = '0;
        rem_trial = '0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (is_mod_q) begin
            rem_shift = {hi_q, lo_q[N-1]};
            rem_trial = rem_shift - {1'b0, opb_q};
            hi_d      = rem_trial[N] ? rem_shift[N-1:0] : rem_trial[N-1:0];
            lo_d      = {lo_q[N-2:0], ~rem_trial[N]};
        end else begin
            mul_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opb_q}) : {1'b0, hi_q};
            hi_d    = mul_sum[N:1];
            lo_d    = {mul_sum[0], lo_q[N-1:1]};
        end
    end

    // Load operands on start, then iterate until the counter runs out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            is_mod_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
        end else if (start) begin
            count_q  <= CW'(N);
            is_mod_q <= (op == OP_MOD);
            hi_q     <= '0;
            lo_q     <= a;
            opb_q    <= b;
        end else if (count_q != '0) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_q - 1'b1;
        end
    end

    // With a zero divisor the restoring loop shifts the dividend into the
    // remainder unchanged, so res already equals a in that case
    always_comb begin
        res   = is_mod_q ? hi_q : lo_q;
        carry = !is_mod_q && (hi_q != '0);
        div0  = is_mod_q && (opb_q == '0);
        last  = (count_q == '0);
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with IDLE/CALC/DONE handshake. Single-cycle ops
// complete on the accepting edge; multiply and modulo iterate for N cycles.
// Define ALU_SEQ_MULDIV_EN to build the iterative mul/mod datapath; without it
// those opcodes behave as reserved (result 0, zero flag set).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ctrl,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] res,
    output logic [3:0]   flags
);

    localparam int SW = $clog2(N);

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic          is_iter;

    logic [N:0]    sum;
    logic [N-1:0]  sc_res;
    logic          sc_carry;
    logic          sc_ovf;

`ifdef ALU_SEQ_MULDIV_EN
    logic [N-1:0]  iter_res;
    logic          iter_carry;
    logic          iter_div0;
    logic          iter_last;

    assign is_iter = (ctrl == OP_MUL) || (ctrl == OP_MOD);

    alu_seq_iter #(.N(N)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (accept && is_iter),
        .op    (opcode_t'(ctrl)),
        .a     (a),
        .b     (b),
        .res   (iter_res),
        .carry (iter_carry),
        .div0  (iter_div0),
        .last  (iter_last)
    );
`else
    assign is_iter = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && start;

    // Single-cycle result and carry/overflow, computed from the live inputs
    always_comb begin
        sum      = '0;
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (ctrl)
            OP_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                sc_res   = sum[N-1:0];
                sc_carry = sum[N];
                sc_ovf   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                sum      = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
                sc_res   = sum[N-1:0];
                sc_carry = sum[N];
                sc_ovf   = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_PASS_A: sc_res = a;
            OP_PASS_B: sc_res = b;
            OP_AND:    sc_res = a & b;
            OP_SHR: begin
                if (b[N-1:SW] == '0) begin
                    sc_res = a >> b[SW-1:0];
                end
            end
            default: sc_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = is_iter ? ST_CALC : ST_DONE;
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_CALC: begin
                if (iter_last) begin
                    state_d = ST_DONE;
                end
            end
`else
            ST_CALC: state_d = ST_IDLE;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        ready = (state_q == ST_IDLE);
        done  = (state_q == ST_DONE);
    end

    // Result and flags change only on the edge that enters DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res   <= '0;
            flags <= '0;
        end else if (accept && !is_iter) begin
            res   <= sc_res;
            flags <= pack_flags(sc_res[N-1], sc_res == '0, sc_carry, sc_ovf);
        end
`ifdef ALU_SEQ_MULDIV_EN
        else if ((state_q == ST_CALC) && iter_last) begin
            res   <= iter_res;
            flags <= pack_flags(iter_res[N-1], iter_res == '0, iter_carry, iter_div0);
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized scoreboard bench for alu_seq. Stimulus pushes the
// reference-model response; an independent monitor pops on every done.
module tb_alu_seq;

    localparam int N = 16;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a     = '0;
    logic [N-1:0] b     = '0;
    logic [3:0]   ctrl  = '0;
    wire          ready;
    wire          done;
    wire  [N-1:0] res;
    wire  [3:0]   flags;

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   flags;
        int           accept;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    alu_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ctrl  (ctrl),
        .ready (ready),
        .done  (done),
        .res   (res),
        .flags (flags)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count rising edges so latency can be measured
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference behaviour from plain arithmetic on the operand values
    function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [3:0] cv);
        exp_t   e;
        longint ua, ub, sa, sbv, r, modv, maxs, mins, p;
        logic   c, v, iter;
        modv = longint'(1) << N;
        maxs = modv / 2 - 1;
        mins = -(modv / 2);
        ua   = longint'(av);
        ub   = longint'(bv);
        sa   = av[N-1] ? ua - modv : ua;
        sbv  = bv[N-1] ? ub - modv : ub;
        r    = 0;
        p    = 0;
        c    = 1'b0;
        v    = 1'b0;
        iter = 1'b0;
        case (cv)
            4'd0: begin
                r = ua + ub;
                c = (r >= modv);
                v = ((sa + sbv) > maxs) || ((sa + sbv) < mins);
            end
            4'd1: begin
                r = ua - ub;
                c = (ua >= ub);
                v = ((sa - sbv) > maxs) || ((sa - sbv) < mins);
            end
            4'd2: r = ua;
            4'd3: r = ub;
            4'd4: begin
`ifdef ALU_SEQ_MULDIV_EN
                iter = 1'b1;
                if (ub == 0) begin
                    r = ua;
                    v = 1'b1;
                end else begin
                    r = ua % ub;
                end
`else
                r = 0;
`endif
            end
            4'd5: r = ua & ub;
            4'd6: begin
`ifdef ALU_SEQ_MULDIV_EN
                iter = 1'b1;
                p    = ua * ub;
                r    = p;
                c    = (p >= modv);
`else
                r = 0;
`endif
            end
            4'd7: r = (ub < N) ? (ua >> ub) : 0;
            default: r = 0;
        endcase
        e.res    = N'(r & (modv - 1));
        e.flags  = {e.res[N-1], e.res == '0, c, v};
        e.lat    = iter ? N + 1 : 1;
        e.accept = 0;
        return e;
    endfunction

    // Issue one operation at a falling edge once the DUT is ready
    task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [3:0] cv);
        exp_t e;
        int   waited;
        waited = 0;
        while (!ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        a        = av;
        b        = bv;
        ctrl     = cv;
        start    = 1'b1;
        e        = model(av, bv, cv);
        e.accept = cycle;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        ctrl  = 4'($urandom);
    endtask

    // Monitor: every done is matched against the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("res", res, e.res);
                checkOutput("flags", flags, e.flags);
                checkOutput("latency", cycle - e.accept, e.lat);
            end
        end
    end

    initial begin
        logic [N-1:0] av, bv;
        logic [3:0]   cv;
        int           guard;

        repeat (2) @(negedge clk);
        checkOutput("reset_res", res, 0);
        checkOutput("reset_flags", flags, 0);
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_done", done, 0);
        rst = 1'b0;

        applyStimulus(16'h7FFF, 16'h0001, 4'b0000);
        applyStimulus(16'h0005, 16'h0005, 4'b0001);
        applyStimulus(16'h8000, 16'd15, 4'b0111);
        applyStimulus(16'h8000, 16'd16, 4'b0111);
        applyStimulus(16'h0000, 16'h0001, 4'b0001);
        applyStimulus(16'h1234, 16'hABCD, 4'b1010);

        applyStimulus(16'h0100, 16'h0100, 4'b0110);
        guard = 0;
        while (!done && guard < 40) begin
            checkOutput("ready_in_calc", ready, 0);
            start = 1'($urandom_range(0, 1));
            ctrl  = 4'($urandom);
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        if (!done) checkOutput("mul_done_timeout", 0, 1);

        applyStimulus(16'd100, 16'd7, 4'b0100);
        applyStimulus(16'd9, 16'd0, 4'b0100);
        applyStimulus(16'd3, 16'd4, 4'b0110);

`ifdef ALU_SEQ_MULDIV_EN
        applyStimulus(16'h1234, 16'h5678, 4'b0110);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        checkOutput("midcalc_reset_res", res, 0);
        checkOutput("midcalc_reset_flags", flags, 0);
        checkOutput("midcalc_reset_ready", ready, 1);
        checkOutput("midcalc_reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
`endif
        applyStimulus(16'd2, 16'd3, 4'b0000);

        for (int i = 0; i < 60; i++) begin
            cv = 4'($urandom_range(0, 15));
            av = N'($urandom);
            case ($urandom_range(0, 3))
                0:       bv = N'($urandom_range(0, N + 2));
                1:       bv = '0;
                default: bv = N'($urandom);
            endcase
            applyStimulus(av, bv, cv);
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) checkOutput("drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter N, 16, operand and result width in bits (N >= 4, power of two).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only while ready=1.
REQ-005 SHALL have port a  input  N  operand A.
REQ-006 SHALL have port b  input  N  operand B.
REQ-007 SHALL have port ctrl  input  4  opcode.
REQ-008 SHALL have port ready  output  1  high only in IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; res/flags valid.
REQ-010 SHALL have port res  output  N  registered result, held until next done.
REQ-011 SHALL have port flags  output  4  registered: bit3 negative, bit2 zero, bit1 carry, bit0 overflow.

Function
REQ-012 SHALL decode ctrl: 0000 add, 0001 sub (a+~b+1), 0010 pass a, 0011 pass b, 0100 a mod b, 0101 a&b, 0110 a*b, 0111 logical shift right a by b.
REQ-013 SHALL treat ctrl 1xxx as reserved: single-cycle, res=0, flags=0100.
REQ-014 SHALL implement FSM IDLE, CALC, DONE; IDLE->DONE for single-cycle ops, IDLE->CALC for mul/mod, CALC->DONE when iteration counter reaches 0, DONE->IDLE unconditionally.
REQ-015 SHALL latch a, b, ctrl on the edge accepting start; later input changes SHALL not affect the operation.
REQ-016 SHALL ignore start while ready=0 (CALC or DONE); no queueing.
REQ-017 SHALL assert done in the cycle after start is accepted for single-cycle ops, and N+1 cycles after acceptance for mul/mod.
REQ-018 SHALL compute mul by shift-add, one bit per CALC cycle, N CALC cycles; res = low N bits of the 2N-bit product; carry = OR of high N bits; overflow=0.
REQ-019 SHALL compute mod by restoring division, one quotient bit per CALC cycle, N CALC cycles; res = remainder.
REQ-020 SHALL on mod with b=0 produce res=a, overflow=1, still taking N+1 cycles.
REQ-021 SHALL for add/sub set carry = carry-out of N-bit sum and overflow = signed overflow; carry=overflow=0 for pass, and, shift.
REQ-022 SHALL shift by b[log2(N)-1:0] when b < N, and produce res=0 when b >= N.
REQ-023 SHALL derive negative=res[N-1] and zero=(res==0) from the final result for every opcode.
REQ-024 SHALL update res and flags only on the edge entering DONE; otherwise hold.

Reset
REQ-025 SHALL on rst, at any time including mid-CALC, force state IDLE, res=0, flags=0000, done=0, ready=1, counter=0, discarding any operation in progress.
REQ-026 SHALL accept a start on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL with macro ALU_SEQ_MULDIV_EN defined include the iterative mul/mod datapath per REQ-018..020.
REQ-028 SHALL without ALU_SEQ_MULDIV_EN treat 0100 and 0110 as reserved per REQ-013 (single-cycle, res=0, flags=0100) and omit CALC logic from synthesis.

Structure
REQ-029 SHALL place opcode enum, FSM state enum and flag bit-index constants in package alu_seq_pkg.
REQ-030 SHALL implement the shift-add/restoring iteration datapath in sub-module alu_seq_iter (start, op, operands in; res, carry, div0, last out), instantiated under ALU_SEQ_MULDIV_EN.

Verification (N=16, macro defined unless stated)
REQ-031 SHALL cover add 0x7FFF+0x0001 -> res 0x8000, flags 1001, done 1 cycle after start.
REQ-032 SHALL cover sub 0x0005-0x0005 -> res 0x0000, flags 0110; shr 0x8000 by 15 -> 0x0001, by 16 -> 0x0000 flags 0100.
REQ-033 SHALL cover mul 0x0100*0x0100 -> res 0x0000, flags 0110, done 17 cycles after start, ready low throughout, start pulses during CALC ignored.
REQ-034 SHALL cover mod 100%7 -> res 0x0002 after 17 cycles; mod 9%0 -> res 0x0009, flags 0001.
REQ-035 SHALL cover rst asserted in 5th CALC cycle of mul -> res 0, flags 0, ready 1, no done; next add 2+3 -> 0x0005.
REQ-036 SHALL cover build without ALU_SEQ_MULDIV_EN: mul 3*4 -> res 0, flags 0100, done 1 cycle after start.
